// File: rtl/dm_cache.sv
// Direct-mapped write-back / write-allocate cache, one data word per line,
// sitting between a CPU request bus and a memory request bus.
module dm_cache #(
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 8,
  parameter int INDEX_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            cpu_req_op,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  input  logic [DATA_WIDTH-1:0] cpu_req_data,
  output logic                  cpu_rsp_vld,
  output logic [DATA_WIDTH-1:0] cpu_rsp_data,
  output logic                  mem_rst,
  output logic [1:0]            mem_req_op,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_data,
  input  logic                  mem_rsp_vld,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic [2:0]            dbg_state
);

  // Handshake on both buses: requester drives a non-NOP op for exactly one
  // cycle, responder later pulses rsp_vld for one cycle; one outstanding
  // transaction per bus.

  localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH;
  localparam int LINES = 1 << INDEX_WIDTH;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WB_REQ    = 3'd1,
    WB_WAIT   = 3'd2,
    FILL_REQ  = 3'd3,
    FILL_WAIT = 3'd4,
    RESP      = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic                  req_wr_q, req_wr_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0] req_data_q, req_data_d;
  logic                  cpu_rsp_vld_q, cpu_rsp_vld_d;
  logic [DATA_WIDTH-1:0] cpu_rsp_data_q, cpu_rsp_data_d;
  logic [1:0]            mem_req_op_q, mem_req_op_d;
  logic [ADDR_WIDTH-1:0] mem_req_addr_q, mem_req_addr_d;
  logic [DATA_WIDTH-1:0] mem_req_data_q, mem_req_data_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [LINES-1:0]      dirty_q, dirty_d;

  // Tag and data storage carry no reset; valid bits gate their use.
  logic [TAG_W-1:0]      tag_mem  [LINES];
  logic [DATA_WIDTH-1:0] data_mem [LINES];

  logic                   line_we;
  logic [INDEX_WIDTH-1:0] line_idx;
  logic [TAG_W-1:0]       line_tag;
  logic [DATA_WIDTH-1:0]  line_data;

  logic [INDEX_WIDTH-1:0] cpu_idx, req_idx;
  logic [TAG_W-1:0]       cpu_tag, req_tag;
  logic                   cpu_is_rd, cpu_is_wr, cpu_hit, victim_dirty;

  assign cpu_idx      = cpu_req_addr[INDEX_WIDTH-1:0];
  assign cpu_tag      = cpu_req_addr[ADDR_WIDTH-1:INDEX_WIDTH];
  assign req_idx      = req_addr_q[INDEX_WIDTH-1:0];
  assign req_tag      = req_addr_q[ADDR_WIDTH-1:INDEX_WIDTH];
  assign cpu_is_rd    = (cpu_req_op == OP_READ);
  assign cpu_is_wr    = (cpu_req_op == OP_WRITE);
  assign cpu_hit      = valid_q[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
  assign victim_dirty = valid_q[cpu_idx] && dirty_q[cpu_idx];

  always_comb begin
    state_d        = state_q;
    req_wr_d       = req_wr_q;
    req_addr_d     = req_addr_q;
    req_data_d     = req_data_q;
    cpu_rsp_vld_d  = 1'b0;
    cpu_rsp_data_d = cpu_rsp_data_q;
    mem_req_op_d   = OP_NOP;
    mem_req_addr_d = mem_req_addr_q;
    mem_req_data_d = mem_req_data_q;
    valid_d        = valid_q;
    dirty_d        = dirty_q;
    line_we        = 1'b0;
    line_idx       = cpu_idx;
    line_tag       = cpu_tag;
    line_data      = cpu_req_data;

    case (state_q)
      IDLE: begin
        if (cpu_is_rd || cpu_is_wr) begin
          req_wr_d   = cpu_is_wr;
          req_addr_d = cpu_req_addr;
          req_data_d = cpu_req_data;
          if (cpu_is_rd && cpu_hit) begin
            cpu_rsp_vld_d  = 1'b1;
            cpu_rsp_data_d = data_mem[cpu_idx];
          end else if (cpu_is_wr && (cpu_hit || !victim_dirty)) begin
            // Write hit or write miss over a clean line: no memory traffic.
            line_we          = 1'b1;
            valid_d[cpu_idx] = 1'b1;
            dirty_d[cpu_idx] = 1'b1;
            cpu_rsp_vld_d    = 1'b1;
          end else if (victim_dirty) begin
            state_d        = WB_REQ;
            mem_req_op_d   = OP_WRITE;
            mem_req_addr_d = {tag_mem[cpu_idx], cpu_idx};
            mem_req_data_d = data_mem[cpu_idx];
          end else begin
            state_d        = FILL_REQ;
            mem_req_op_d   = OP_READ;
            mem_req_addr_d = cpu_req_addr;
          end
        end
      end
      WB_REQ: state_d = WB_WAIT;
      WB_WAIT: begin
        if (mem_rsp_vld) begin
          dirty_d[req_idx] = 1'b0;
          if (req_wr_q) begin
            line_we          = 1'b1;
            line_idx         = req_idx;
            line_tag         = req_tag;
            line_data        = req_data_q;
            valid_d[req_idx] = 1'b1;
            dirty_d[req_idx] = 1'b1;
            cpu_rsp_vld_d    = 1'b1;
            state_d          = RESP;
          end else begin
            state_d        = FILL_REQ;
            mem_req_op_d   = OP_READ;
            mem_req_addr_d = req_addr_q;
          end
        end
      end
      FILL_REQ: state_d = FILL_WAIT;
      FILL_WAIT: begin
        if (mem_rsp_vld) begin
          line_we          = 1'b1;
          line_idx         = req_idx;
          line_tag         = req_tag;
          line_data        = mem_rsp_data;
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = 1'b0;
          cpu_rsp_vld_d    = 1'b1;
          cpu_rsp_data_d   = mem_rsp_data;
          state_d          = RESP;
        end
      end
      // The response pulse was registered on entry, so RESP just retires.
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      req_wr_q       <= 1'b0;
      req_addr_q     <= '0;
      req_data_q     <= '0;
      cpu_rsp_vld_q  <= 1'b0;
      cpu_rsp_data_q <= '0;
      mem_req_op_q   <= OP_NOP;
      mem_req_addr_q <= '0;
      mem_req_data_q <= '0;
      valid_q        <= '0;
      dirty_q        <= '0;
    end else begin
      state_q        <= state_d;
      req_wr_q       <= req_wr_d;
      req_addr_q     <= req_addr_d;
      req_data_q     <= req_data_d;
      cpu_rsp_vld_q  <= cpu_rsp_vld_d;
      cpu_rsp_data_q <= cpu_rsp_data_d;
      mem_req_op_q   <= mem_req_op_d;
      mem_req_addr_q <= mem_req_addr_d;
      mem_req_data_q <= mem_req_data_d;
      valid_q        <= valid_d;
      dirty_q        <= dirty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem[line_idx]  <= line_tag;
      data_mem[line_idx] <= line_data;
    end
  end

  assign cpu_rsp_vld  = cpu_rsp_vld_q;
  assign cpu_rsp_data = cpu_rsp_data_q;
  assign mem_req_op   = mem_req_op_q;
  assign mem_req_addr = mem_req_addr_q;
  assign mem_req_data = mem_req_data_q;
  assign mem_rst      = !rst_n;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_dm_cache.sv
// Directed bench for dm_cache: fills, hits, write allocation, dirty eviction,
// ignored stray requests/responses and reset in the middle of a writeback.
module tb_dm_cache;

  logic       clk;
  logic       rst_n;
  logic [1:0] cpu_req_op;
  logic [5:0] cpu_req_addr;
  logic [7:0] cpu_req_data;
  logic       cpu_rsp_vld;
  logic [7:0] cpu_rsp_data;
  logic       mem_rst;
  logic [1:0] mem_req_op;
  logic [5:0] mem_req_addr;
  logic [7:0] mem_req_data;
  logic       mem_rsp_vld;
  logic [7:0] mem_rsp_data;
  logic [2:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int n_mem_rd = 0;
  int n_mem_wr = 0;

  // Observed bundle: {cpu_rsp_vld, cpu_rsp_data, mem_req_op, state}
  logic [13:0] obs;
  logic [13:0] exp;
  assign obs = {cpu_rsp_vld, cpu_rsp_data, mem_req_op, dbg_state};

  dm_cache #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .INDEX_WIDTH(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_req_op   (cpu_req_op),
    .cpu_req_addr (cpu_req_addr),
    .cpu_req_data (cpu_req_data),
    .cpu_rsp_vld  (cpu_rsp_vld),
    .cpu_rsp_data (cpu_rsp_data),
    .mem_rst      (mem_rst),
    .mem_req_op   (mem_req_op),
    .mem_req_addr (mem_req_addr),
    .mem_req_data (mem_req_data),
    .mem_rsp_vld  (mem_rsp_vld),
    .mem_rsp_data (mem_rsp_data),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory-side transaction counter, sampled after the edge settles
  always @(posedge clk) begin
    #2;
    if (rst_n && mem_req_op == 2'd1) n_mem_rd++;
    if (rst_n && mem_req_op == 2'd2) n_mem_wr++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick();
    exp = {1'b0, 8'h00, 2'd0, 3'd0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL reset_outputs: observed=%h expected=%h", obs, exp); end
    n_cmp++; if ({mem_rst, mem_req_addr, mem_req_data} !== {1'b1, 6'h00, 8'h00}) begin n_err++; $display("FAIL reset_mem_bus: observed=%h expected=%h", {mem_rst, mem_req_addr, mem_req_data}, {1'b1, 14'h0}); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if ({mem_rst, obs} !== 15'h0) begin n_err++; $display("FAIL reset_release: observed=%h expected=0", {mem_rst, obs}); end
  endtask

  task automatic test_read_miss();
    int rd0 = n_mem_rd;
    cpu_req_op = 2'd1; cpu_req_addr = 6'h05;
    tick(); cpu_req_op = 2'd0;
    exp = {1'b0, 8'h00, 2'd1, 3'd3};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL rd_miss_fill_req: observed=%h expected=%h", obs, exp); end
    n_cmp++; if (mem_req_addr !== 6'h05) begin n_err++; $display("FAIL rd_miss_addr: observed=%h expected=05", mem_req_addr); end
    tick();
    exp = {1'b0, 8'h00, 2'd0, 3'd4};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL rd_miss_wait1: observed=%h expected=%h", obs, exp); end
    tick();
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL rd_miss_wait2: observed=%h expected=%h", obs, exp); end
    tick(); mem_rsp_vld = 1'b1; mem_rsp_data = 8'hA5;
    tick(); mem_rsp_vld = 1'b0;
    exp = {1'b1, 8'hA5, 2'd0, 3'd5};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL rd_miss_rsp: observed=%h expected=%h", obs, exp); end
    tick();
    exp = {1'b0, 8'hA5, 2'd0, 3'd0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL rd_miss_done: observed=%h expected=%h", obs, exp); end
    n_cmp++; if (n_mem_rd - rd0 !== 1) begin n_err++; $display("FAIL rd_miss_one_read: observed=%0d expected=1", n_mem_rd - rd0); end
  endtask

  task automatic test_read_hit();
    int t0 = n_mem_rd + n_mem_wr;
    cpu_req_op = 2'd1; cpu_req_addr = 6'h05;
    tick(); cpu_req_op = 2'd0;
    exp = {1'b1, 8'hA5, 2'd0, 3'd0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL rd_hit_rsp: observed=%h expected=%h", obs, exp); end
    tick();
    exp = {1'b0, 8'hA5, 2'd0, 3'd0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL rd_hit_done: observed=%h expected=%h", obs, exp); end
    n_cmp++; if (n_mem_rd + n_mem_wr - t0 !== 0) begin n_err++; $display("FAIL rd_hit_no_mem: observed=%0d expected=0", n_mem_rd + n_mem_wr - t0); end
  endtask

  task automatic test_back_to_back();
    int t0 = n_mem_rd + n_mem_wr;
    cpu_req_op = 2'd2; cpu_req_addr = 6'h0D; cpu_req_data = 8'h3C;
    tick(); cpu_req_op = 2'd1; cpu_req_addr = 6'h0D;
    exp = {1'b1, 8'hA5, 2'd0, 3'd0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL wr_miss_ack: observed=%h expected=%h", obs, exp); end
    tick(); cpu_req_op = 2'd0;
    exp = {1'b1, 8'h3C, 2'd0, 3'd0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL rd_after_wr: observed=%h expected=%h", obs, exp); end
    tick();
    exp = {1'b0, 8'h3C, 2'd0, 3'd0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL b2b_done: observed=%h expected=%h", obs, exp); end
    n_cmp++; if (n_mem_rd + n_mem_wr - t0 !== 0) begin n_err++; $display("FAIL wr_miss_no_mem: observed=%0d expected=0", n_mem_rd + n_mem_wr - t0); end
  endtask

  task automatic test_dirty_evict();
    cpu_req_op = 2'd1; cpu_req_addr = 6'h15;
    tick(); cpu_req_op = 2'd0;
    exp = {1'b0, 8'h3C, 2'd2, 3'd1};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL ev_wb_req: observed=%h expected=%h", obs, exp); end
    n_cmp++; if ({mem_req_addr, mem_req_data} !== {6'h0D, 8'h3C}) begin n_err++; $display("FAIL ev_wb_addr_data: observed=%h expected=%h", {mem_req_addr, mem_req_data}, {6'h0D, 8'h3C}); end
    tick();
    exp = {1'b0, 8'h3C, 2'd0, 3'd2};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL ev_wb_wait: observed=%h expected=%h", obs, exp); end
    tick(); mem_rsp_vld = 1'b1; mem_rsp_data = 8'h00;
    tick(); mem_rsp_vld = 1'b0;
    exp = {1'b0, 8'h3C, 2'd1, 3'd3};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL ev_fill_req: observed=%h expected=%h", obs, exp); end
    n_cmp++; if (mem_req_addr !== 6'h15) begin n_err++; $display("FAIL ev_fill_addr: observed=%h expected=15", mem_req_addr); end
    tick();
    exp = {1'b0, 8'h3C, 2'd0, 3'd4};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL ev_fill_wait: observed=%h expected=%h", obs, exp); end
    tick(); mem_rsp_vld = 1'b1; mem_rsp_data = 8'h77;
    tick(); mem_rsp_vld = 1'b0;
    exp = {1'b1, 8'h77, 2'd0, 3'd5};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL ev_rsp: observed=%h expected=%h", obs, exp); end
    tick();
    exp = {1'b0, 8'h77, 2'd0, 3'd0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL ev_done: observed=%h expected=%h", obs, exp); end
  endtask

  task automatic test_ignored();
    int rd0 = n_mem_rd;
    int wr0 = n_mem_wr;
    cpu_req_op = 2'd1; cpu_req_addr = 6'h25;
    tick(); cpu_req_op = 2'd0;
    exp = {1'b0, 8'h77, 2'd1, 3'd3};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL ign_fill_req: observed=%h expected=%h", obs, exp); end
    tick(); cpu_req_op = 2'd1; cpu_req_addr = 6'h05;
    exp = {1'b0, 8'h77, 2'd0, 3'd4};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL ign_in_wait: observed=%h expected=%h", obs, exp); end
    tick(); cpu_req_op = 2'd0;
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL ign_cpu_req: observed=%h expected=%h", obs, exp); end
    tick(); mem_rsp_vld = 1'b1; mem_rsp_data = 8'h5A;
    tick(); mem_rsp_vld = 1'b0;
    exp = {1'b1, 8'h5A, 2'd0, 3'd5};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL ign_fill_rsp: observed=%h expected=%h", obs, exp); end
    tick(); mem_rsp_vld = 1'b1; mem_rsp_data = 8'hEE;
    tick(); mem_rsp_vld = 1'b0;
    exp = {1'b0, 8'h5A, 2'd0, 3'd0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL ign_mem_rsp: observed=%h expected=%h", obs, exp); end
    cpu_req_op = 2'd1; cpu_req_addr = 6'h25;
    tick(); cpu_req_op = 2'd0;
    exp = {1'b1, 8'h5A, 2'd0, 3'd0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL ign_line_intact: observed=%h expected=%h", obs, exp); end
    tick();
    n_cmp++; if ({n_mem_rd - rd0, n_mem_wr - wr0} !== {32'd1, 32'd0}) begin n_err++; $display("FAIL ign_mem_traffic: observed rd=%0d wr=%0d expected rd=1 wr=0", n_mem_rd - rd0, n_mem_wr - wr0); end
  endtask

  task automatic test_reset_mid();
    cpu_req_op = 2'd2; cpu_req_addr = 6'h1D; cpu_req_data = 8'h99;
    tick(); cpu_req_op = 2'd1; cpu_req_addr = 6'h15;
    exp = {1'b1, 8'h5A, 2'd0, 3'd0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL rm_wr_ack: observed=%h expected=%h", obs, exp); end
    tick(); cpu_req_op = 2'd0;
    exp = {1'b0, 8'h5A, 2'd2, 3'd1};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL rm_wb_req: observed=%h expected=%h", obs, exp); end
    n_cmp++; if ({mem_req_addr, mem_req_data} !== {6'h1D, 8'h99}) begin n_err++; $display("FAIL rm_wb_addr_data: observed=%h expected=%h", {mem_req_addr, mem_req_data}, {6'h1D, 8'h99}); end
    tick();
    exp = {1'b0, 8'h5A, 2'd0, 3'd2};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL rm_wb_wait: observed=%h expected=%h", obs, exp); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({mem_rst, obs, mem_req_addr, mem_req_data} !== {1'b1, 28'h0}) begin n_err++; $display("FAIL rm_in_reset: observed=%h expected=%h", {mem_rst, obs, mem_req_addr, mem_req_data}, {1'b1, 28'h0}); end
    tick();
    n_cmp++; if ({mem_rst, obs} !== {1'b1, 14'h0}) begin n_err++; $display("FAIL rm_reset_hold: observed=%h expected=%h", {mem_rst, obs}, {1'b1, 14'h0}); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (mem_rst !== 1'b0) begin n_err++; $display("FAIL rm_mem_rst_release: observed=%b expected=0", mem_rst); end
    cpu_req_op = 2'd1; cpu_req_addr = 6'h15;
    tick(); cpu_req_op = 2'd0;
    exp = {1'b0, 8'h00, 2'd1, 3'd3};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL rm_fresh_fill: observed=%h expected=%h", obs, exp); end
    n_cmp++; if (mem_req_addr !== 6'h15) begin n_err++; $display("FAIL rm_fill_addr: observed=%h expected=15", mem_req_addr); end
    tick();
    tick(); mem_rsp_vld = 1'b1; mem_rsp_data = 8'h42;
    tick(); mem_rsp_vld = 1'b0;
    exp = {1'b1, 8'h42, 2'd0, 3'd5};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL rm_fill_rsp: observed=%h expected=%h", obs, exp); end
    tick();
    exp = {1'b0, 8'h42, 2'd0, 3'd0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL rm_done: observed=%h expected=%h", obs, exp); end
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_req_op = 2'd0; cpu_req_addr = 6'h00; cpu_req_data = 8'h00;
    mem_rsp_vld = 1'b0; mem_rsp_data = 8'h00;
    test_reset();
    test_read_miss();
    test_read_hit();
    test_back_to_back();
    test_dirty_evict();
    test_ignored();
    test_reset_mid();
    n_cmp++; if ({n_mem_rd, n_mem_wr} !== {32'd4, 32'd2}) begin n_err++; $display("FAIL total_mem_traffic: observed rd=%0d wr=%0d expected rd=4 wr=2", n_mem_rd, n_mem_wr); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dm_cache.md
Name: dm_cache

Overview:
- Direct-mapped, write-back, write-allocate cache between the CPU-side request bus (rx role) and the memory-side request bus (tx role).
- Both buses use the team's Op / addr / data / rsp_vld request–response protocol.
- Consumes CPU requests, serves hits locally, and issues memory READ/WRITE transactions for fills and dirty evictions.
- One data word per line, so a line fill is a single memory READ.

Parameters:
ADDR_WIDTH, 6, width of UbitAddr on both buses
DATA_WIDTH, 8, width of UbitData on both buses
INDEX_WIDTH, 3, line index bits (2**INDEX_WIDTH lines); tag = addr[ADDR_WIDTH-1:INDEX_WIDTH]

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
cpu_req_op  in  2  Op: NOP=0, READ=1, WRITE=2 (3 reserved, treated as NOP)
cpu_req_addr  in  ADDR_WIDTH  CPU request address
cpu_req_data  in  DATA_WIDTH  CPU write data
cpu_rsp_vld  out  1  one-cycle pulse: request complete (read data valid / write ack)
cpu_rsp_data  out  DATA_WIDTH  read data, valid when cpu_rsp_vld and op was READ
mem_rst  out  1  = !rst_n, combinational, drives the memory-side bus reset
mem_req_op  out  2  Op to memory, non-NOP for exactly one cycle per transaction
mem_req_addr  out  ADDR_WIDTH  memory address
mem_req_data  out  DATA_WIDTH  writeback data
mem_rsp_vld  in  1  memory completion pulse
mem_rsp_data  in  DATA_WIDTH  memory read data

Behaviour:
- Protocol on both buses:
  - Requester drives a non-NOP op for one cycle.
  - Responder later pulses rsp_vld for one cycle.
  - At most one outstanding transaction per bus.
- Storage per line: valid, dirty, tag, data. Reset clears all valid/dirty bits; tag/data are don't-care.
- Reset values: cpu_rsp_vld=0, cpu_rsp_data=0, mem_req_op=NOP, mem_req_addr=0, mem_req_data=0, FSM=IDLE.
- cpu_rsp_data holds its last value between responses.
- Request capture:
  - Captured (op/addr/data registered) only in IDLE when cpu_req_op is READ or WRITE.
  - Requests in any other state are ignored.
- FSM states: IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, RESP.
- IDLE, request at cycle T:
  - Hit (valid && tag match):
    - READ: cpu_rsp_vld=1, cpu_rsp_data=line data at T+1.
    - WRITE: line data updated, dirty=1, cpu_rsp_vld=1 at T+1.
    - Stay in IDLE; a new request may be captured at T+1.
  - Miss, victim clean or invalid:
    - READ: go to FILL_REQ.
    - WRITE: allocate immediately (tag=new, data=wdata, valid=1, dirty=1); cpu_rsp_vld at T+1. No memory traffic.
  - Miss, victim valid && dirty: go to WB_REQ.
- WB_REQ (one cycle):
  - mem_req_op=WRITE, mem_req_addr={victim tag, index}, mem_req_data=victim data.
  - Next state WB_WAIT.
- WB_WAIT, on mem_rsp_vld:
  - Clear dirty.
  - READ request: go to FILL_REQ.
  - WRITE request: allocate as on a clean write miss, go to RESP.
- FILL_REQ (one cycle): mem_req_op=READ, mem_req_addr=captured addr. Next state FILL_WAIT.
- FILL_WAIT, on mem_rsp_vld:
  - Line gets valid=1, dirty=0, tag=new, data=mem_rsp_data.
  - Go to RESP with data = mem_rsp_data.
- RESP (one cycle): cpu_rsp_vld=1 (data for READ). Next state IDLE.
- Latencies:
  - Hit, or clean write miss: 1 cycle.
  - Read miss, memory response at cycle M: cpu_rsp_vld at M+1.
- mem_req_op is NOP in every state except WB_REQ and FILL_REQ.
- mem_rsp_vld outside WB_WAIT/FILL_WAIT is ignored. No timeout; the FSM waits indefinitely.
- Reset asserted mid-transaction:
  - Immediate return to reset values; all lines invalid.
  - The outstanding memory transaction is abandoned; mem_rst also resets the memory.
- Address bits: index = addr[INDEX_WIDTH-1:0]. No byte enables. Widths are exact, no truncation.

Test Plan:
1. Read 0x05 after reset; memory returns 0xA5 three cycles after the READ pulse -> exactly one mem READ at addr 0x05; cpu_rsp_vld one cycle after mem_rsp_vld with data 0xA5.
2. Re-read 0x05 -> no mem traffic; cpu_rsp_vld at T+1 with data 0xA5.
3. Write 0x3C to 0x0D (same index 5, clean victim) -> no mem traffic; ack at T+1. Then read 0x0D -> 0x3C at T+1.
4. Read 0x15 (index 5, victim 0x0D dirty):
   - mem WRITE addr 0x0D data 0x3C, then after mem_rsp_vld a mem READ at 0x15.
   - Memory returns 0x77 -> cpu data 0x77.
5. Pulse cpu_req_op=READ while in FILL_WAIT, and pulse mem_rsp_vld while in IDLE -> both ignored; no state, line, or output change.
6. Assert rst_n=0 during WB_WAIT; release; read 0x15 -> all outputs at reset values during reset; mem_rst=1 while rst_n=0; the read misses and a fresh mem READ 0x15 is issued.
